// File: rtl/ultrasonic_ranger_ctrl_if.sv
// User-side bundle of the ultrasonic ranger: measurement request/mode
// inputs and the status/result outputs.
interface ultrasonic_ranger_ctrl_if;
  logic        start;
  logic        cont;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] echo_us;
  logic [15:0] dist_cm;

  modport master (
    output start, cont,
    input  busy, done, timeout, echo_us, dist_cm
  );

  modport slave (
    input  start, cont,
    output busy, done, timeout, echo_us, dist_cm
  );
endinterface

// File: rtl/ultrasonic_ranger_ctrl.sv
// Ultrasonic ranging sequencer: derives a 1 us tick enable from clk, fires
// the sensor trigger, times the echo pulse and converts its width to
// centimetres with a running sub-counter instead of a divider.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start or continuous mode
// TRIG      | driving trig high for TRIG_US ticks
// WAIT_RISE | waiting for a fresh echo rising edge, bounded by TIMEOUT_US
// MEASURE   | counting echo width in us and cm until the falling edge
// TIMEOUT   | one cycle: publish all-ones results with timeout set
// HOLDOFF   | quiet time of HOLDOFF_US ticks before the next trigger
module ultrasonic_ranger_ctrl #(
  parameter int unsigned TICK_DIV   = 50,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned HOLDOFF_US = 30000,
  parameter int unsigned US_PER_CM  = 58
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          echo,
  output logic                          trig,
  ultrasonic_ranger_ctrl_if.slave       bus
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [15:0]      TRIG_LAST = 16'(TRIG_US - 1);
  localparam logic [15:0]      TO_LAST   = 16'(TIMEOUT_US - 1);
  localparam logic [15:0]      HOLD_LAST = 16'(HOLDOFF_US - 1);
  localparam logic [5:0]       SUB_LAST  = 6'(US_PER_CM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_TIMEOUT,
    S_HOLDOFF
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             echo_m;
  logic             echo_s;
  logic             echo_d;
  logic             rise;
  logic             fall;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [15:0]      us_cnt;

  logic [15:0]      echo_cnt;
  logic [15:0]      cm_cnt;
  logic [5:0]       sub_cnt;

  logic             meas_clr;
  logic             load_ok;
  logic             load_to;

  logic             trig_q;
  logic             done_q;
  logic             timeout_q;
  logic [15:0]      echo_us_q;
  logic [15:0]      dist_cm_q;

  assign rise = echo_s & ~echo_d;
  assign fall = ~echo_s & echo_d;
  assign tick = (div_cnt == DIV_LAST);

  // Two-flop synchroniser on echo plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the one-cycle result-load strobes.
  always_comb begin
    state_nxt = state;
    meas_clr  = 1'b0;
    load_ok   = 1'b0;
    load_to   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start || bus.cont) state_nxt = S_TRIG;
      end
      S_TRIG: begin
        if (tick && (us_cnt == TRIG_LAST)) state_nxt = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        // Only an edge counts, so an echo already high on entry is ignored.
        if (rise) begin
          state_nxt = S_MEASURE;
          meas_clr  = 1'b1;
        end else if (tick && (us_cnt == TO_LAST)) begin
          state_nxt = S_TIMEOUT;
        end
      end
      S_MEASURE: begin
        if (fall) begin
          state_nxt = S_HOLDOFF;
          load_ok   = 1'b1;
        end else if (tick && (echo_cnt == TO_LAST)) begin
          state_nxt = S_TIMEOUT;
        end
      end
      S_TIMEOUT: begin
        state_nxt = S_HOLDOFF;
        load_to   = 1'b1;
      end
      S_HOLDOFF: begin
        if (tick && (us_cnt == HOLD_LAST)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tick prescaler and phase us counter, restarted on every state change so
  // each phase begins on a tick boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      us_cnt  <= '0;
    end else if (state_nxt != state) begin
      div_cnt <= '0;
      us_cnt  <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      us_cnt  <= us_cnt + 16'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Echo width in us and cm; the sub-counter wraps every US_PER_CM ticks so
  // cm_cnt always equals floor(echo_cnt / US_PER_CM).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_cnt <= '0;
      cm_cnt   <= '0;
      sub_cnt  <= '0;
    end else if (meas_clr) begin
      echo_cnt <= '0;
      cm_cnt   <= '0;
      sub_cnt  <= '0;
    end else if ((state == S_MEASURE) && tick) begin
      echo_cnt <= echo_cnt + 16'd1;
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        cm_cnt  <= cm_cnt + 16'd1;
      end else begin
        sub_cnt <= sub_cnt + 6'd1;
      end
    end
  end

  // Registered outputs: trigger, done strobe and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      echo_us_q <= '0;
      dist_cm_q <= '0;
    end else begin
      trig_q <= (state_nxt == S_TRIG);
      done_q <= load_ok | load_to;
      if (load_ok) begin
        echo_us_q <= echo_cnt;
        dist_cm_q <= cm_cnt;
        timeout_q <= 1'b0;
      end else if (load_to) begin
        echo_us_q <= 16'hFFFF;
        dist_cm_q <= 16'hFFFF;
        timeout_q <= 1'b1;
      end
    end
  end

  assign trig        = trig_q;
  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;
  assign bus.echo_us = echo_us_q;
  assign bus.dist_cm = dist_cm_q;

endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// Bench for ultrasonic_ranger_ctrl with shortened timing parameters.
`timescale 1ns/1ps
module tb_ultrasonic_ranger_ctrl;

  localparam int D  = 5;    // clocks per us
  localparam int T  = 4;    // trigger width, us
  localparam int TO = 400;  // echo timeout, us
  localparam int H  = 60;   // holdoff, us
  localparam int K  = 7;    // us per cm

  logic clk = 1'b0;
  logic rst_n;
  logic echo;
  logic trig;

  ultrasonic_ranger_ctrl_if rif();

  ultrasonic_ranger_ctrl #(
    .TICK_DIV   (D),
    .TRIG_US    (T),
    .TIMEOUT_US (TO),
    .HOLDOFF_US (H),
    .US_PER_CM  (K)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .echo  (echo),
    .trig  (trig),
    .bus   (rif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int cyc        = 0;
  int done_cnt   = 0;
  int trig_rises = 0;
  int last_rise  = 0;
  int last_gap   = 0;
  logic trig_p   = 1'b0;

  // Observes done pulses and trigger rising edges.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rif.done) done_cnt <= done_cnt + 1;
    if (trig && !trig_p) begin
      if (trig_rises > 0) last_gap <= cyc - last_rise;
      last_rise  <= cyc;
      trig_rises <= trig_rises + 1;
    end
    trig_p <= trig;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic start_pulse(input string tag);
    @(negedge clk);
    rif.start = 1'b1;
    @(negedge clk);
    rif.start = 1'b0;
    chk({tag, "_trig_lat"}, 32'(trig), 1);
  endtask

  // Waits for trig (if not already high) and returns its high width in clocks.
  task automatic trig_pulse(output int len, output bit ok);
    int i;
    i = 0; len = 0; ok = 1'b0;
    while (!trig && i < 5000) begin @(negedge clk); i++; end
    if (!trig) return;
    while (trig && len < 5000) begin @(negedge clk); len++; end
    ok = !trig;
  endtask

  task automatic do_echo(input int dly_us, input int w_us);
    repeat (dly_us * D) @(negedge clk);
    echo = 1'b1;
    repeat (w_us * D) @(negedge clk);
    echo = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int n);
    n = 0;
    while (!rif.done && n < budget) begin @(negedge clk); n++; end
    ok = rif.done;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (rif.busy && i < (H * D + 200)) begin @(negedge clk); i++; end
    chk({tag, "_idle"}, 32'(rif.busy), 0);
  endtask

  // Reference: a W us echo yields echo_us within W +/- 1 and
  // dist_cm = floor(echo_us / K), so dist lies in [(W-1)/K, (W+1)/K].
  task automatic check_ok(input string tag, input int w);
    int eu, dc;
    eu = int'(rif.echo_us);
    dc = int'(rif.dist_cm);
    chk({tag, "_timeout"}, 32'(rif.timeout), 0);
    chk({tag, "_echo_rng"}, 32'(eu >= w - 1 && eu <= w + 1), 1);
    chk({tag, "_dist_rng"}, 32'(dc >= (w - 1) / K && dc <= (w + 1) / K), 1);
    chk({tag, "_dist_floor"}, 32'(dc * K <= eu && eu < dc * K + K), 1);
  endtask

  task automatic check_to(input string tag);
    chk({tag, "_timeout"}, 32'(rif.timeout), 1);
    chk({tag, "_echo_us"}, 32'(rif.echo_us), 32'hFFFF);
    chk({tag, "_dist_cm"}, 32'(rif.dist_cm), 32'hFFFF);
  endtask

  task automatic run_single(input string tag, input int dly, input int w);
    int len, n, d0;
    bit ok;
    d0 = done_cnt;
    start_pulse(tag);
    trig_pulse(len, ok);
    chk({tag, "_trig_len"}, 32'(len), 32'(T * D));
    do_echo(dly, w);
    wait_done(100, ok, n);
    chk({tag, "_done_seen"}, 32'(ok), 1);
    check_ok(tag, w);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(rif.done), 0);
    wait_idle(tag);
    chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 1);
  endtask

  initial begin
    #(10ns * 80000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, n, d0, t0, dly, w;
    bit ok;
    rst_n = 1'b0; echo = 1'b0; rif.start = 1'b0; rif.cont = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_trig",    32'(trig),        0);
    chk("rst_busy",    32'(rif.busy),    0);
    chk("rst_done",    32'(rif.done),    0);
    chk("rst_timeout", 32'(rif.timeout), 0);
    chk("rst_echo_us", 32'(rif.echo_us), 0);
    chk("rst_dist_cm", 32'(rif.dist_cm), 0);

    // Nominal: 73 us echo -> 72..74 us -> 10 cm.
    run_single("nom", 20, 73);
    chk("nom_dist", 32'(rif.dist_cm), 10);

    for (int i = 0; i < 4; i++) begin
      dly = int'($urandom_range(50, 1));
      w   = int'($urandom_range(350, 8));
      run_single("rnd", dly, w);
    end

    // No echo: timeout after TO us of WAIT_RISE, then a full holdoff.
    start_pulse("noe");
    trig_pulse(len, ok);
    chk("noe_trig_len", 32'(len), 32'(T * D));
    wait_done(TO * D + 100, ok, n);
    chk("noe_done_seen", 32'(ok), 1);
    chk("noe_latency", 32'(n >= TO * D && n <= TO * D + 2), 1);
    check_to("noe");
    n = 0;
    while (rif.busy && n < H * D + 100) begin @(negedge clk); n++; end
    chk("noe_holdoff", 32'(n >= H * D - 1 && n <= H * D + 1), 1);

    // Echo already high before the trigger and never falls.
    echo = 1'b1;
    repeat (10) @(negedge clk);
    start_pulse("pre");
    trig_pulse(len, ok);
    wait_done(TO * D + 100, ok, n);
    chk("pre_done_seen", 32'(ok), 1);
    check_to("pre");
    echo = 1'b0;
    wait_idle("pre");

    // Valid rise, then stuck high: timeout after TO us of measuring.
    start_pulse("stk");
    trig_pulse(len, ok);
    repeat (10 * D) @(negedge clk);
    echo = 1'b1;
    wait_done(TO * D + 100, ok, n);
    chk("stk_done_seen", 32'(ok), 1);
    chk("stk_latency", 32'(n >= TO * D && n <= TO * D + 10), 1);
    check_to("stk");
    echo = 1'b0;
    wait_idle("stk");

    // Start while busy is ignored.
    d0 = done_cnt; t0 = trig_rises;
    start_pulse("sbz");
    trig_pulse(len, ok);
    repeat (10 * D) @(negedge clk);
    echo = 1'b1;
    repeat (30 * D) @(negedge clk);
    rif.start = 1'b1;
    @(negedge clk);
    rif.start = 1'b0;
    repeat (30 * D) @(negedge clk);
    echo = 1'b0;
    wait_done(100, ok, n);
    check_ok("sbz", 61);
    wait_idle("sbz");
    repeat (50) @(negedge clk);
    chk("sbz_done_cnt", 32'(done_cnt - d0), 1);
    chk("sbz_trig_cnt", 32'(trig_rises - t0), 1);

    // Continuous mode: 143 us echo -> 142..144 us -> 20 cm.
    @(negedge clk);
    rif.cont = 1'b1;
    for (int i = 0; i < 3; i++) begin
      trig_pulse(len, ok);
      chk("cont_trig_seen", 32'(ok), 1);
      if (i > 0) chk("cont_gap", 32'(last_gap >= (T + 143 + H) * D), 1);
      do_echo(5, 143);
      wait_done(100, ok, n);
      chk("cont_done_seen", 32'(ok), 1);
      chk("cont_dist", 32'(rif.dist_cm), 20);
      chk("cont_timeout", 32'(rif.timeout), 0);
    end
    @(negedge clk);
    rif.cont = 1'b0;
    t0 = trig_rises;
    repeat (H * D + 100) @(negedge clk);
    chk("cont_stop_trig", 32'(trig_rises - t0), 0);
    chk("cont_stop_busy", 32'(rif.busy), 0);

    // Reset asserted mid-MEASURE clears everything at once.
    start_pulse("rmm");
    trig_pulse(len, ok);
    repeat (3 * D) @(negedge clk);
    echo = 1'b1;
    repeat (20 * D) @(negedge clk);
    chk("rmm_pre_busy", 32'(rif.busy), 1);
    chk("rmm_pre_echo_us", 32'(rif.echo_us != 0), 1);
    rst_n = 1'b0;
    #1;
    chk("rmm_trig",    32'(trig),        0);
    chk("rmm_busy",    32'(rif.busy),    0);
    chk("rmm_echo_us", 32'(rif.echo_us), 0);
    chk("rmm_dist_cm", 32'(rif.dist_cm), 0);
    echo = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rmm_after_busy", 32'(rif.busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
